// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Main control unit of a multicycle MIPS-style datapath. A twelve-state Moore
// FSM steps each instruction through fetch, decode and its execute/memory/
// write-back states, driving the datapath mux selects and write enables.
//
// Optional feature (compile-time macro): MULTICYCLE_MEM_WAIT_EN
//   When defined, FETCH, MEMREAD and MEMWRITE hold until MemReady=1. PCWrite
//   and IRWrite are qualified by MemReady in FETCH so the PC advances exactly
//   once per fetch. When undefined, MemReady is ignored.
//
// Ports
//   clk          in   clock, rising-edge active
//   reset        in   asynchronous active-high reset, forces FETCH
//   Opcode[3:0]  in   IR[15:12]; sampled in DECODE and MEMADDR only
//   MemReady     in   memory-access-complete (wait-state build only)
//   PCWrite      out  unconditional PC load
//   PCWriteCond  out  PC load qualified externally by ALU Zero
//   IRWrite      out  instruction register load
//   MemRead      out  memory read strobe
//   MemWrite     out  memory write strobe
//   IorD         out  memory address select: 0 PC, 1 ALUOut
//   RegWrite     out  register file write enable
//   RegDst       out  write register select: 0 rt, 1 rd
//   MemtoReg     out  write data select: 0 ALUOut, 1 MDR
//   ALUSrcA      out  ALU A select: 0 PC, 1 register A
//   ALUSrcB[1:0] out  ALU B select: 00 B, 01 const 1, 10/11 sign-ext imm
//   ALUOp[1:0]   out  11 add, 01 subtract, 00 decode Function field
//   PCSource[1:0]out  PC mux: 00 ALU result, 01 ALUOut, 10 jump target
//   State[3:0]   out  current state code (debug)
//   IllegalOp    out  one-cycle pulse in the FETCH following a DECODE of an
//                     illegal opcode
// ---------------------------------------------------------------------------
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Opcode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] State,
    output logic       IllegalOp
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADDR  = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXEC     = 4'd6,
        RWB      = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        IMMEXEC  = 4'd10,
        IMMWB    = 4'd11
    } state_t;

    typedef enum logic [3:0] {
        OP_RTYPE = 4'b0000,
        OP_LW    = 4'b0001,
        OP_SW    = 4'b0010,
        OP_BEQ   = 4'b0011,
        OP_ADDI  = 4'b0100,
        OP_J     = 4'b0101
    } opcode_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // Control word for each state; anything not set stays 0.
    function automatic ctrl_t decode_state(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b11;
                c.pc_write  = 1'b1;
            end
            DECODE: begin
                c.alu_src_b = 2'b11;
                c.alu_op    = 2'b11;
            end
            MEMADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = 2'b11;
            end
            MEMREAD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            MEMWRITE: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            EXEC: begin
                c.alu_src_a = 1'b1;
            end
            RWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            IMMEXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = 2'b11;
            end
            IMMWB: begin
                c.reg_write = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t state_q, state_d;
    ctrl_t  ctrl_q;
    logic   illegal_q, illegal_d;
    logic   mem_go;

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign mem_go = MemReady;
`else
    // MemReady has no role without wait states.
    logic unused_mem_ready;
    assign unused_mem_ready = MemReady;
    assign mem_go           = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        case (state_q)
            FETCH:    state_d = mem_go ? DECODE : FETCH;
            DECODE: begin
                case (Opcode)
                    OP_RTYPE:     state_d = EXEC;
                    OP_LW, OP_SW: state_d = MEMADDR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = IMMEXEC;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d   = FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            // Only SW goes to MEMWRITE; everything else reaching here is a load.
            MEMADDR:  state_d = (Opcode == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD:  state_d = mem_go ? MEMWB : MEMREAD;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = mem_go ? FETCH : MEMWRITE;
            EXEC:     state_d = RWB;
            RWB:      state_d = FETCH;
            BRANCH:   state_d = FETCH;
            JUMP:     state_d = FETCH;
            IMMEXEC:  state_d = IMMWB;
            IMMWB:    state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    // The control word is registered from the next state, so it always equals
    // the decode of the state register (Moore) without a combinational decoder.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            ctrl_q    <= decode_state(FETCH);
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= decode_state(state_d);
            illegal_q <= illegal_d;
        end
    end

    // Fetch-side PC/IR loads wait for the memory so a stalled fetch cannot
    // bump the PC more than once; JUMP's PCWrite is unaffected.
    logic fetch_hold;
    assign fetch_hold = (state_q == FETCH) && !mem_go;

    assign PCWrite     = ctrl_q.pc_write & ~fetch_hold;
    assign PCWriteCond = ctrl_q.pc_write_cond;
    assign IRWrite     = ctrl_q.ir_write & ~fetch_hold;
    assign MemRead     = ctrl_q.mem_read;
    assign MemWrite    = ctrl_q.mem_write;
    assign IorD        = ctrl_q.iord;
    assign RegWrite    = ctrl_q.reg_write;
    assign RegDst      = ctrl_q.reg_dst;
    assign MemtoReg    = ctrl_q.mem_to_reg;
    assign ALUSrcA     = ctrl_q.alu_src_a;
    assign ALUSrcB     = ctrl_q.alu_src_b;
    assign ALUOp       = ctrl_q.alu_op;
    assign PCSource    = ctrl_q.pc_source;
    assign State       = state_q;
    assign IllegalOp   = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level reference model feeds a
// scoreboard of per-cycle expectations; a monitor checks them on negedges.
module tb_multicycle_control;

`ifdef MULTICYCLE_MEM_WAIT_EN
    localparam bit WAIT_MODE = 1'b1;
`else
    localparam bit WAIT_MODE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Opcode;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, IorD;
    logic       RegWrite, RegDst, MemtoReg, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;
    logic       IllegalOp;

    multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .Opcode     (Opcode),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .PCWriteCond(PCWriteCond),
        .IRWrite    (IRWrite),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IorD       (IorD),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .PCSource   (PCSource),
        .State      (State),
        .IllegalOp  (IllegalOp)
    );

    always #5 clk = ~clk;

    // {PCWrite,PCWriteCond,IRWrite,MemRead,MemWrite,IorD,RegWrite,RegDst,
    //  MemtoReg,ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0]}
    logic [15:0] dut_ctl;
    assign dut_ctl = {PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, IorD,
                      RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    // Control word listed per state code 0..11.
    localparam logic [15:0] CTL_TAB [12] = '{
        16'hB01C, 16'h003C, 16'h006C, 16'h1400, 16'h0280, 16'h0C00,
        16'h0040, 16'h0300, 16'h4045, 16'h8002, 16'h006C, 16'h0200};

    function automatic logic [15:0] spec_ctl(input int st, input bit ready);
        logic [15:0] v;
        v = CTL_TAB[st];
        if (st == 0 && !ready) v = v & ~16'hA000;  // no PCWrite/IRWrite while fetch waits
        return v;
    endfunction

    typedef struct {
        logic [3:0]  st;
        logic [15:0] ctl;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    bit pending_ill = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: one expectation per cycle, checked mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("state", 32'(State), 32'(e.st));
                chk("ctrl", 32'(dut_ctl), 32'(e.ctl));
                chk("illegal", 32'(IllegalOp), 32'(e.ill));
            end
        end
    end

    // Called at posedge+2 of a FETCH cycle; returns at posedge+2 of the next
    // FETCH cycle, or (stop_at_memread) on entry to MEMREAD without checking it.
    task automatic run_instr(input logic [3:0] op, input bit stop_at_memread);
        int path[$];
        int st;
        bit ready, first, is_mem;
        exp_t e;
        case (op)
            4'd0:    path = '{0, 1, 6, 7};
            4'd1:    path = '{0, 1, 2, 3, 4};
            4'd2:    path = '{0, 1, 2, 5};
            4'd3:    path = '{0, 1, 8};
            4'd4:    path = '{0, 1, 10, 11};
            4'd5:    path = '{0, 1, 9};
            default: path = '{0, 1};
        endcase
        for (int i = 0; i < path.size(); i++) begin
            st = path[i];
            if (i > 0) begin
                @(posedge clk);
                #2;
            end
            if (stop_at_memread && st == 3) return;
            is_mem = (st == 0 || st == 3 || st == 5);
            first  = 1'b1;
            forever begin
                ready    = is_mem ? ($urandom_range(0, 2) != 0) : 1'($urandom_range(0, 1));
                MemReady = ready;
                // Opcode is only meaningful in DECODE/MEMADDR; scramble it elsewhere.
                Opcode   = (st == 1 || st == 2) ? op : 4'($urandom_range(0, 15));
                e.st  = 4'(st);
                e.ctl = spec_ctl(st, WAIT_MODE ? ready : 1'b1);
                e.ill = (st == 0) && first && pending_ill;
                sb.push_back(e);
                if (!(WAIT_MODE && is_mem && !ready)) break;
                @(posedge clk);
                #2;
                first = 1'b0;
            end
        end
        pending_ill = (op > 4'd5);
        @(posedge clk);
        #2;
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, time %0t expected below 1000000", $time);
        n_bad++;
        summary();
        $finish;
    end

    initial begin
        logic [3:0] op;
        reset    = 1'b1;
        Opcode   = 4'hF;
        MemReady = 1'b0;
        #3;
        chk("reset_state", 32'(State), 32'd0);
        chk("reset_ctrl", 32'(dut_ctl), 32'(spec_ctl(0, !WAIT_MODE)));
        chk("reset_illegal", 32'(IllegalOp), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("reset_hold_state", 32'(State), 32'd0);
        reset = 1'b0;

        // Directed: R-type, LW, BEQ, illegal, then a legal op to see the pulse.
        run_instr(4'd0, 1'b0);
        run_instr(4'd1, 1'b0);
        run_instr(4'd3, 1'b0);
        run_instr(4'hF, 1'b0);
        run_instr(4'd2, 1'b0);

        // Reset asserted mid-instruction while in MEMREAD.
        run_instr(4'd1, 1'b1);
        chk("pre_reset_state", 32'(State), 32'd3);
        #1 reset = 1'b1;
        #1;
        chk("async_reset_state", 32'(State), 32'd0);
        chk("async_reset_memwrite", 32'(MemWrite), 32'd0);
        chk("async_reset_regwrite", 32'(RegWrite), 32'd0);
        chk("async_reset_ctrl", 32'(dut_ctl), 32'(spec_ctl(0, WAIT_MODE ? MemReady : 1'b1)));
        chk("async_reset_illegal", 32'(IllegalOp), 32'd0);
        @(posedge clk);
        #2;
        chk("reset_hold2_state", 32'(State), 32'd0);
        reset       = 1'b0;
        pending_ill = 1'b0;

        // Randomized instruction stream, mostly legal.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) != 0) op = 4'($urandom_range(0, 5));
            else                           op = 4'($urandom_range(6, 15));
            run_instr(op, 1'b0);
        end

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        summary();
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high; forces FETCH immediately.
REQ-003 Opcode  in  4  instruction [15:12] from IR; 0000 R-type, 0001 LW, 0010 SW, 0011 BEQ, 0100 ADDI, 0101 J; others illegal.
REQ-004 MemReady  in  1  memory-access-complete handshake; used only with MEM_WAIT_EN.
REQ-005 PCWrite  out  1  unconditional PC load.
REQ-006 PCWriteCond  out  1  PC load qualified by ALU Zero (external AND).
REQ-007 IRWrite  out  1  instruction register load.
REQ-008 MemRead  out  1  memory read strobe.
REQ-009 MemWrite  out  1  memory write strobe.
REQ-010 IorD  out  1  memory address select: 0 PC, 1 ALUOut.
REQ-011 RegWrite  out  1  register file write enable.
REQ-012 RegDst  out  1  write register select: 0 rt, 1 rd.
REQ-013 MemtoReg  out  1  write data select: 0 ALUOut, 1 MDR.
REQ-014 ALUSrcA  out  1  ALU A select: 0 PC, 1 register A.
REQ-015 ALUSrcB  out  2  ALU B select: 00 reg B, 01 constant 1, 10 sign-ext imm, 11 sign-ext imm (branch offset).
REQ-016 ALUOp  out  2  to ALU control: 11 add, 01 subtract, 00 decode Function field, 10 unused.
REQ-017 PCSource  out  2  PC mux: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-018 State  out  4  current state encoding, for debug/verification.
REQ-019 IllegalOp  out  1  one-cycle pulse when DECODE sees an illegal opcode.

Function
REQ-020 The FSM SHALL use states FETCH=0, DECODE=1, MEMADDR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, IMMEXEC=10, IMMWB=11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-021 All outputs SHALL be Moore-decoded from the state register only; any output not listed for a state SHALL be 0.
REQ-022 FETCH: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=11, PCWrite=1, PCSource=00; next DECODE.
REQ-023 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=11; next by Opcode: LW/SW->MEMADDR, R->EXEC, BEQ->BRANCH, ADDI->IMMEXEC, J->JUMP, illegal->FETCH with IllegalOp=1.
REQ-024 MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=11; next MEMREAD for LW, MEMWRITE for SW.
REQ-025 MEMREAD: MemRead=1, IorD=1; next MEMWB. MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; next FETCH.
REQ-026 MEMWRITE: MemWrite=1, IorD=1; next FETCH.
REQ-027 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=00; next RWB. RWB: RegWrite=1, RegDst=1, MemtoReg=0; next FETCH.
REQ-028 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; next FETCH.
REQ-029 JUMP: PCWrite=1, PCSource=10; next FETCH.
REQ-030 IMMEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=11; next IMMWB. IMMWB: RegWrite=1, RegDst=0, MemtoReg=0; next FETCH.
REQ-031 Cycles per instruction without wait states SHALL be: LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3.
REQ-032 Opcode SHALL be sampled only in DECODE and MEMADDR; changes elsewhere SHALL have no effect.

Reset
REQ-033 Asserting reset SHALL force State=FETCH asynchronously, mid-instruction included; outputs SHALL show FETCH decode during reset, IllegalOp=0; first advance SHALL be on the first rising edge after deassertion.

Configuration
REQ-034 With MULTICYCLE_MEM_WAIT_EN defined, FETCH, MEMREAD and MEMWRITE SHALL hold state and outputs while MemReady=0 and advance on an edge with MemReady=1; in FETCH, PCWrite and IRWrite SHALL be gated by MemReady so PC increments exactly once.
REQ-035 Without MULTICYCLE_MEM_WAIT_EN, MemReady SHALL be ignored and every memory state SHALL last exactly one cycle.

Verification
REQ-036 Release reset, Opcode=0000 -> State 0,1,6,7,0; RegWrite=1 and RegDst=1 only in cycle 4.
REQ-037 Opcode=0001 -> State 0,1,2,3,4,0; MemRead=1 in states 0 and 3; MemtoReg=1 only in state 4.
REQ-038 Opcode=0011 -> State 0,1,8,0; ALUOp=01 and PCWriteCond=1 in state 8; Opcode=1111 -> State 0,1,0 with IllegalOp=1 for one cycle.
REQ-039 Assert reset mid-cycle in state 3 -> State=0 before the next clock edge, MemWrite=0, RegWrite=0.
REQ-040 MULTICYCLE_MEM_WAIT_EN, SW, MemReady=0 for 3 cycles in state 5 -> State stays 5 with MemWrite=1 for 4 cycles, then 0; in FETCH with MemReady low, PCWrite=0.
